// File: rtl/ladybird_uart_loader.sv
// UART boot loader: parses SYNC/ADDR/COUNT/DATA/CSUM frames from a byte stream
// and issues word-wide memory writes, with an inter-byte timeout abort.
module ladybird_uart_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [19:0] TIMEOUT   = 20'hFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, WRITE, CSUM} state_t;

  state_t      state;
  logic [31:0] shift;
  logic [1:0]  idx;
  logic [7:0]  csum;
  logic [15:0] remaining;
  logic [19:0] tcnt;
  logic        accept;
  logic [31:0] word;

  assign accept = in_valid & in_ready;
  // Bytes arrive LSB first, so each new byte enters at the top and shifts down.
  assign word   = {in_data, shift[31:8]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      mem_valid <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      shift     <= 32'd0;
      idx       <= 2'd0;
      csum      <= 8'd0;
      remaining <= 16'd0;
      tcnt      <= 20'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && in_data == SYNC_BYTE) begin
            state <= ADDR;
            busy  <= 1'b1;
            error <= 1'b0;
            csum  <= 8'd0;
            idx   <= 2'd0;
            tcnt  <= 20'd0;
          end
        end

        WRITE: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            mem_addr  <= mem_addr + 32'd4;
            remaining <= remaining - 16'd1;
            in_ready  <= 1'b1;
            idx       <= 2'd0;
            tcnt      <= 20'd0;
            state     <= (remaining == 16'd1) ? CSUM : DATA;
          end
        end

        default: begin
          // Timeout wins over a byte arriving in the same cycle; any partial word is dropped.
          if (tcnt == TIMEOUT) begin
            state    <= IDLE;
            busy     <= 1'b0;
            in_ready <= 1'b1;
            error    <= 1'b1;
            idx      <= 2'd0;
          end else if (accept) begin
            tcnt  <= 20'd0;
            shift <= word;
            idx   <= idx + 2'd1;
            if (state != CSUM) csum <= csum ^ in_data;
            case (state)
              ADDR: begin
                if (idx == 2'd3) begin
                  mem_addr <= {word[31:2], 2'b00};
                  idx      <= 2'd0;
                  state    <= LEN;
                end
              end
              LEN: begin
                if (idx == 2'd1) begin
                  remaining <= word[31:16];
                  idx       <= 2'd0;
                  state     <= (word[31:16] != 16'd0) ? DATA : CSUM;
                end
              end
              DATA: begin
                if (idx == 2'd3) begin
                  mem_wdata <= word;
                  mem_valid <= 1'b1;
                  in_ready  <= 1'b0;
                  state     <= WRITE;
                end
              end
              CSUM: begin
                if (in_data == csum) done <= 1'b1;
                else error <= 1'b1;
                state <= IDLE;
                busy  <= 1'b0;
                idx   <= 2'd0;
              end
              default: ;
            endcase
          end else begin
            tcnt <= tcnt + 20'd1;
          end
        end
      endcase
    end
  end

endmodule
